// File: rtl/cpu65_addr_pkg.sv
// Shared select encodings for the 65xx address-bus block.
// Used by addr_bus_unit and by anything that drives its ADL/ADH selects.
package cpu65_addr_pkg;

   typedef logic [2:0] adl_sel_t;
   typedef logic [2:0] adh_sel_t;

   localparam adl_sel_t ADL_SEL_PC   = 3'd0;
   localparam adl_sel_t ADL_SEL_DATA = 3'd1;
   localparam adl_sel_t ADL_SEL_S    = 3'd2;
   localparam adl_sel_t ADL_SEL_ALU  = 3'd3;
   localparam adl_sel_t ADL_SEL_VEC  = 3'd4;
   localparam adl_sel_t ADL_SEL_ZERO = 3'd5;

   localparam adh_sel_t ADH_SEL_PC   = 3'd0;
   localparam adh_sel_t ADH_SEL_DATA = 3'd1;
   localparam adh_sel_t ADH_SEL_ALU  = 3'd2;
   localparam adh_sel_t ADH_SEL_ZERO = 3'd3;
   localparam adh_sel_t ADH_SEL_ONE  = 3'd4;
   localparam adh_sel_t ADH_SEL_FF   = 3'd5;

   localparam logic [7:0] STACK_PAGE  = 8'h01;
   localparam logic [7:0] VECTOR_PAGE = 8'hFF;

endpackage

// File: rtl/addr_reg8.sv
// 8-bit address byte register with load enable and asynchronous reset value.
// Instantiated once for ABL and once for ABH.
module addr_reg8 #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic [7:0] d_i,
   output logic [7:0] q_o
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   // NOTE: default to the current value so a missing branch holds state instead of inferring a latch.
   always_comb begin
      q_d = q_q;
      if (load_i) q_d = d_i;
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= RESET_VAL;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/addr_bus_unit.sv
// ADL/ADH source muxing and ABL/ABH address registers of the 65xx core.
// Define ADDR_READY_GATE_EN to qualify the ABL/ABH loads with ready.
module addr_bus_unit
   import cpu65_addr_pkg::*;
#(
   parameter logic [15:0] RESET_ADDR = 16'hFFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  adl_sel_t    adl_sel,
   input  adh_sel_t    adh_sel,
   input  logic        load_abl,
   input  logic        load_abh,
   input  logic        ready,
   input  logic [7:0]  data_i,
   input  logic [7:0]  pcls,
   input  logic [7:0]  pchs,
   input  logic [7:0]  reg_s,
   input  logic [7:0]  alu,
   input  logic [7:0]  vector_lo,
   output logic [7:0]  adl_abl,
   output logic [7:0]  adl_pcls,
   output logic [7:0]  adh_abh,
   output logic [7:0]  adh_pchs,
   output logic [15:0] address
);

   logic       load_abl_eff;
   logic       load_abh_eff;
   logic [7:0] abl;
   logic [7:0] abh;

   // Reserved select codes fall back to the PC source toward ABL/ABH.
   always_comb begin
      adl_abl  = pcls;
      adl_pcls = data_i;
      case (adl_sel)
         ADL_SEL_PC:   adl_abl = pcls;
         ADL_SEL_DATA: adl_abl = data_i;
         ADL_SEL_S: begin
            adl_abl  = reg_s;
            adl_pcls = reg_s;
         end
         ADL_SEL_ALU: begin
            adl_abl  = alu;
            adl_pcls = alu;
         end
         ADL_SEL_VEC:  adl_abl = vector_lo;
         ADL_SEL_ZERO: adl_abl = 8'h00;
         default:      adl_abl = pcls;
      endcase
   end

   always_comb begin
      adh_abh  = pchs;
      adh_pchs = data_i;
      case (adh_sel)
         ADH_SEL_PC:   adh_abh = pchs;
         ADH_SEL_DATA: adh_abh = data_i;
         ADH_SEL_ALU: begin
            adh_abh  = alu;
            adh_pchs = alu;
         end
         ADH_SEL_ZERO: adh_abh = 8'h00;
         ADH_SEL_ONE:  adh_abh = STACK_PAGE;
         ADH_SEL_FF:   adh_abh = VECTOR_PAGE;
         default:      adh_abh = pchs;
      endcase
   end

`ifdef ADDR_READY_GATE_EN
   assign load_abl_eff = load_abl & ready;
   assign load_abh_eff = load_abh & ready;
`else
   logic unused_ready;
   assign unused_ready = ready;
   assign load_abl_eff = load_abl;
   assign load_abh_eff = load_abh;
`endif

   addr_reg8 #(
      .RESET_VAL (RESET_ADDR[7:0])
   ) u_abl (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_abl_eff),
      .d_i    (adl_abl),
      .q_o    (abl)
   );

   addr_reg8 #(
      .RESET_VAL (RESET_ADDR[15:8])
   ) u_abh (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_abh_eff),
      .d_i    (adh_abh),
      .q_o    (abh)
   );

   assign address = {abh, abl};

endmodule

// File: tb/tb_addr_bus_unit.sv
// Self-checking bench for addr_bus_unit: table-driven mux sweep plus
// scoreboarded address-register sequences (reset, stack, split loads, ready).
module tb_addr_bus_unit;
   import cpu65_addr_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   adl_sel_t    adl_sel;
   adh_sel_t    adh_sel;
   logic        load_abl, load_abh, ready;
   logic [7:0]  data_i, pcls, pchs, reg_s, alu, vector_lo;
   logic [7:0]  adl_abl, adl_pcls, adh_abh, adh_pchs;
   logic [15:0] address;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];

   typedef struct {
      logic [2:0] sel;
      logic [7:0] exp_adl_abl;
      logic [7:0] exp_adl_pcls;
      logic [7:0] exp_adh_abh;
      logic [7:0] exp_adh_pchs;
   } mux_vec_t;

   mux_vec_t vecs[8];

   addr_bus_unit #(.RESET_ADDR(16'hFFFC)) dut (
      .clk       (clk),
      .reset     (reset),
      .adl_sel   (adl_sel),
      .adh_sel   (adh_sel),
      .load_abl  (load_abl),
      .load_abh  (load_abh),
      .ready     (ready),
      .data_i    (data_i),
      .pcls      (pcls),
      .pchs      (pchs),
      .reg_s     (reg_s),
      .alu       (alu),
      .vector_lo (vector_lo),
      .adl_abl   (adl_abl),
      .adl_pcls  (adl_pcls),
      .adh_abh   (adh_abh),
      .adh_pchs  (adh_pchs),
      .address   (address)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock edge, then compare address against the oldest queued expectation.
   task automatic step(input string name);
      logic [15:0] exp;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty, got %h", name, address);
      end else begin
         exp = exp_q.pop_front();
         check(name, address, exp);
      end
   endtask

   initial begin
      vecs[0] = '{3'd0, 8'h11, 8'h22, 8'h66, 8'h22};
      vecs[1] = '{3'd1, 8'h22, 8'h22, 8'h22, 8'h22};
      vecs[2] = '{3'd2, 8'h33, 8'h33, 8'h44, 8'h44};
      vecs[3] = '{3'd3, 8'h44, 8'h44, 8'h00, 8'h22};
      vecs[4] = '{3'd4, 8'h55, 8'h22, 8'h01, 8'h22};
      vecs[5] = '{3'd5, 8'h00, 8'h22, 8'hFF, 8'h22};
      vecs[6] = '{3'd6, 8'h11, 8'h22, 8'h66, 8'h22};
      vecs[7] = '{3'd7, 8'h11, 8'h22, 8'h66, 8'h22};

      // Reset asserted from time 0 with both loads active.
      reset     = 1'b1;
      load_abl  = 1'b1;
      load_abh  = 1'b1;
      ready     = 1'b1;
      adl_sel   = ADL_SEL_DATA;
      adh_sel   = ADH_SEL_DATA;
      data_i    = 8'h5A;
      pcls      = 8'h11;
      pchs      = 8'h66;
      reg_s     = 8'h33;
      alu       = 8'h44;
      vector_lo = 8'h55;
      #2;
      check("reset_immediate", address, 16'hFFFC);
      @(posedge clk);
      #1;
      check("reset_held_over_edge", address, 16'hFFFC);

      data_i = 8'h22;
      for (int i = 0; i < 8; i++) begin
         adl_sel = vecs[i].sel;
         adh_sel = vecs[i].sel;
         #1;
         check($sformatf("adl_abl_sel%0d", i),  {8'h00, adl_abl},  {8'h00, vecs[i].exp_adl_abl});
         check($sformatf("adl_pcls_sel%0d", i), {8'h00, adl_pcls}, {8'h00, vecs[i].exp_adl_pcls});
         check($sformatf("adh_abh_sel%0d", i),  {8'h00, adh_abh},  {8'h00, vecs[i].exp_adh_abh});
         check($sformatf("adh_pchs_sel%0d", i), {8'h00, adh_pchs}, {8'h00, vecs[i].exp_adh_pchs});
      end
      check("reset_held_during_sweep", address, 16'hFFFC);

      // Release reset between edges with loads idle.
      @(negedge clk);
      load_abl = 1'b0;
      load_abh = 1'b0;
      reset    = 1'b0;
      #1;
      check("reset_release", address, 16'hFFFC);

      // Stack access: {01, S}.
      adl_sel  = ADL_SEL_S;
      reg_s    = 8'hFD;
      adh_sel  = ADH_SEL_ONE;
      load_abl = 1'b1;
      load_abh = 1'b1;
      exp_q.push_back(16'h01FD);
      step("stack_access");

      // ABL alone.
      adl_sel  = ADL_SEL_ALU;
      alu      = 8'h80;
      adh_sel  = ADH_SEL_DATA;
      data_i   = 8'hC3;
      load_abl = 1'b1;
      load_abh = 1'b0;
      exp_q.push_back(16'h0180);
      step("load_abl_only");

      // ABH alone.
      adh_sel  = ADH_SEL_ALU;
      alu      = 8'h12;
      adl_sel  = ADL_SEL_DATA;
      load_abl = 1'b0;
      load_abh = 1'b1;
      exp_q.push_back(16'h1280);
      step("load_abh_only");

      // No loads: hold.
      adl_sel  = ADL_SEL_ZERO;
      adh_sel  = ADH_SEL_FF;
      load_abl = 1'b0;
      load_abh = 1'b0;
      exp_q.push_back(16'h1280);
      step("hold_no_load");

      // Vector fetch address {FF, vector_lo}.
      adl_sel   = ADL_SEL_VEC;
      vector_lo = 8'hFE;
      load_abl  = 1'b1;
      load_abh  = 1'b1;
      exp_q.push_back(16'hFFFE);
      step("vector_fetch");

      // ready low with loads asserted.
      adl_sel = ADL_SEL_DATA;
      adh_sel = ADH_SEL_DATA;
      data_i  = 8'hAA;
      ready   = 1'b0;
`ifdef ADDR_READY_GATE_EN
      exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'hFFFE);
`else
      exp_q.push_back(16'hAAAA);
      exp_q.push_back(16'hAAAA);
`endif
      step("ready_low_1");
      step("ready_low_2");
      ready = 1'b1;
      exp_q.push_back(16'hAAAA);
      step("ready_high");

      // Mid-cycle reset with loads active, then mid-cycle release.
      data_i = 8'h5A;
      #2;
      reset = 1'b1;
      #1;
      check("midcycle_reset_async", address, 16'hFFFC);
      @(posedge clk);
      #1;
      check("midcycle_reset_over_edge", address, 16'hFFFC);
      #2;
      reset = 1'b0;
      #1;
      check("midcycle_release_no_load", address, 16'hFFFC);
      exp_q.push_back(16'h5A5A);
      step("load_after_release");

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addr_bus_unit.md
Name: addr_bus_unit

Overview:
- Address-bus source selection and address-register block of the 65xx core.
- Combinationally routes the low/high internal address buses (ADL/ADH) from PC-select, data-in, S, ALU, vector and constant-page sources.
- Feeds the PC-select logic (adl_pcls, adh_pchs) and latches the external address into ABL/ABH registers.
- Address output is {abh, abl}.

Parameters:
- RESET_ADDR, 16'hFFFC, value loaded into {abh, abl} on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- adl_sel  input  3  ADL source select
- adh_sel  input  3  ADH source select
- load_abl  input  1  ABL register load enable
- load_abh  input  1  ABH register load enable
- ready  input  1  CPU ready; used only when the optional feature is compiled in
- data_i  input  8  external data bus input
- pcls  input  8  selected next PCL
- pchs  input  8  selected next PCH
- reg_s  input  8  stack pointer
- alu  input  8  ALU result
- vector_lo  input  8  interrupt/reset vector low byte
- adl_abl  output  8  ADL bus; feeds ABL and ALU-B
- adl_pcls  output  8  ADL bus toward PCL select
- adh_abh  output  8  ADH bus toward ABH
- adh_pchs  output  8  ADH bus toward PCH select
- address  output  16  {abh, abl}

Behaviour:
- ADL select encoding: 0 PC, 1 DATA, 2 S, 3 ALU, 4 VEC, 5 ZERO, 6 and 7 reserved.
- ADH select encoding: 0 PC, 1 DATA, 2 ALU, 3 ZERO, 4 ONE, 5 FF, 6 and 7 reserved.
- adl_abl (combinational): PC→pcls, DATA→data_i, S→reg_s, ALU→alu, VEC→vector_lo, ZERO→8'h00, reserved→pcls.
- adl_pcls (combinational): S→reg_s, ALU→alu, all other codes→data_i.
- adh_abh (combinational): PC→pchs, DATA→data_i, ALU→alu, ZERO→8'h00, ONE→8'h01 (stack page), FF→8'hFF (vector page), reserved→pchs.
- adh_pchs (combinational): ALU→alu, all other codes→data_i.
- Mux outputs have zero latency. They have no dependence on clk or reset and contain no latches.
- abl: on rising edge of clk, abl←adl_abl when load_abl=1; otherwise holds.
- abh: on rising edge of clk, abh←adh_abh when load_abh=1; otherwise holds.
- ABL and ABH load independently. Loading one register never alters the other.
- address = {abh, abl}. An updated value is visible the cycle after the load.
- Reset: asynchronously sets {abh, abl}=RESET_ADDR. Reset has priority over loads. Deasserting reset mid-cycle gives no load until the next rising edge.
- No carry or wrap logic in this block. Page arithmetic happens in the ALU; values pass through unmodified.

Optional Feature:
- Macro: ADDR_READY_GATE_EN.
- Defined: effective loads are load_abl&ready and load_abh&ready, so the address holds while ready=0.
- Undefined: ready is ignored and loads follow load_abl/load_abh directly.
- Muxes are combinational and unaffected in both cases.

Decomposition:
- Shared package cpu65_addr_pkg holds:
  - ADL_SEL_PC, ADL_SEL_DATA, ADL_SEL_S, ADL_SEL_ALU, ADL_SEL_VEC, ADL_SEL_ZERO
  - ADH_SEL_PC, ADH_SEL_DATA, ADH_SEL_ALU, ADH_SEL_ZERO, ADH_SEL_ONE, ADH_SEL_FF
  - 3-bit select typedefs
- One natural sub-module, addr_reg8: an 8-bit register with async reset value and load enable, instantiated for ABL and ABH.

Test Plan:
- Reset: assert reset mid-cycle with load_abl=load_abh=1 → address=16'hFFFC immediately and held while reset is high.
- ADL mux sweep: pcls=11, data_i=22, reg_s=33, alu=44, vector_lo=55, sweep adl_sel 0..5 → adl_abl = 11, 22, 33, 44, 55, 00; adl_pcls = 22, 22, 33, 44, 22, 22.
- ADH mux sweep: pchs=66, data_i=22, alu=44, sweep adh_sel 0..5 → adh_abh = 66, 22, 44, 00, 01, FF; adh_pchs = 22, 22, 44, 22, 22, 22.
- Stack access: adl_sel=S, reg_s=FD, adh_sel=ONE, both loads=1, one clock → address=16'h01FD.
- Independent loads: from 01FD, adl_sel=ALU, alu=80, load_abl=1, load_abh=0 → address=16'h0180 one cycle later.
- Ready gate (ADDR_READY_GATE_EN): ready=0, loads=1, data_i=AA with DATA selects → address unchanged. ready=1 → address=16'hAAAA next edge. Without the macro the load occurs regardless of ready.
